// File: rtl/cpu_exc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_exc_pkg
//  Brief    : Shared CP0 register numbers, exception codes and next-PC selects.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_exc_pkg;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam logic [4:0] EXC_INT    = 5'd0;
    localparam logic [4:0] EXC_SYS    = 5'd8;
    localparam logic [4:0] EXC_UNIMPL = 5'd10;
    localparam logic [4:0] EXC_OVF    = 5'd12;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'b00,
        SEL_EPC = 2'b10,
        SEL_VEC = 2'b11
    } selpc_e;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0008;

    // Cause as seen by mfc0: live synchronised irq at bit 8, ExcCode at [6:2].
    function automatic logic [31:0] cause_word(input logic irq_s, input logic [4:0] code);
        return {23'd0, irq_s, 1'b0, code, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_sync.sv
`default_nettype none
// ============================================================================
//  Module   : irq_sync
//  Brief    : Multi-flop synchroniser for the asynchronous irq line.
//  Revision : 1.0 - initial release
// ============================================================================
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clrn,
    input  logic irq,
    output logic irq_s
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
        end
    end

    assign irq_s = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/cp0_exc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cp0_exc_ctrl
//  Brief    : CP0 Status/Cause/EPC, irq synchronisation and exception priority.
//  Revision : 1.0 - initial release
// ============================================================================
module cp0_exc_ctrl
    import cpu_exc_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEFAULT,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] pc,
    input  logic        inst_valid,
    input  logic        irq,
    input  logic        exc_sys,
    input  logic        exc_unimpl,
    input  logic        exc_ovf,
    input  logic        is_eret,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic [1:0]  selpc,
    output logic [31:0] epc_out,
    output logic [31:0] vec_out,
    output logic        kill
);

    logic [11:0] status_q, status_d;
    logic [4:0]  code_q,   code_d;
    logic [31:0] epc_q,    epc_d;

    logic        w_irq_s;
    logic        w_ovf, w_unimpl, w_sys, w_int;
    logic        w_exc_take, w_eret_take, w_mtc0;
    logic [4:0]  w_exc_code;
    selpc_e      w_sel;

    irq_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk   (clk),
        .clrn  (clrn),
        .irq   (irq),
        .irq_s (w_irq_s)
    );

    assign w_ovf    = inst_valid & exc_ovf    & status_q[3];
    assign w_unimpl = inst_valid & exc_unimpl & status_q[2];
    assign w_sys    = inst_valid & exc_sys    & status_q[1];
    assign w_int    = inst_valid & w_irq_s    & status_q[0];

    assign w_exc_take  = w_ovf | w_unimpl | w_sys | w_int;
    assign w_eret_take = inst_valid & is_eret & ~w_exc_take;
    assign w_mtc0      = inst_valid & cp0_we  & ~w_exc_take;

    always_comb begin
        if (w_ovf)         w_exc_code = EXC_OVF;
        else if (w_unimpl) w_exc_code = EXC_UNIMPL;
        else if (w_sys)    w_exc_code = EXC_SYS;
        else               w_exc_code = EXC_INT;
    end

    // Status acts as a 3-deep enable stack: entry pushes a zero group, eret pops.
    always_comb begin
        status_d = status_q;
        code_d   = code_q;
        epc_d    = epc_q;
        if (w_exc_take) begin
            epc_d    = pc;
            code_d   = w_exc_code;
            status_d = {status_q[7:0], 4'b0000};
        end else begin
            if (w_eret_take) begin
                status_d = {4'b0000, status_q[11:4]};
            end
            if (w_mtc0) begin
                case (cp0_addr)
                    CP0_STATUS: status_d = cp0_wdata[11:0];
                    CP0_CAUSE:  code_d   = cp0_wdata[6:2];
                    CP0_EPC:    epc_d    = cp0_wdata;
                    default:    ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            status_q <= '0;
            code_q   <= '0;
            epc_q    <= '0;
        end else begin
            status_q <= status_d;
            code_q   <= code_d;
            epc_q    <= epc_d;
        end
    end

    // The eret path is gated by clrn so the mux stays sequential during reset.
    always_comb begin
        if (!clrn)            w_sel = SEL_SEQ;
        else if (w_exc_take)  w_sel = SEL_VEC;
        else if (w_eret_take) w_sel = SEL_EPC;
        else                  w_sel = SEL_SEQ;
    end

    always_comb begin
        case (cp0_addr)
            CP0_STATUS: cp0_rdata = {20'd0, status_q};
            CP0_CAUSE:  cp0_rdata = cause_word(w_irq_s, code_q);
            CP0_EPC:    cp0_rdata = epc_q;
            default:    cp0_rdata = 32'd0;
        endcase
    end

    assign selpc   = w_sel;
    assign kill    = w_exc_take;
    assign epc_out = epc_q;
    assign vec_out = EXC_VECTOR;

endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cp0_exc_ctrl
//  Brief    : Self-checking bench for cp0_exc_ctrl with a behavioural CP0 model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_exc_ctrl;

    localparam int SYNC = 2;

    logic        clk;
    logic        clrn;
    logic [31:0] pc;
    logic        inst_valid, irq, exc_sys, exc_unimpl, exc_ovf, is_eret, cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [1:0]  selpc;
    logic [31:0] epc_out;
    logic [31:0] vec_out;
    logic        kill;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    logic [11:0] m_status;
    logic [4:0]  m_code;
    logic [31:0] m_epc;
    logic        m_hist[$];

    cp0_exc_ctrl dut (
        .clk        (clk),
        .clrn       (clrn),
        .pc         (pc),
        .inst_valid (inst_valid),
        .irq        (irq),
        .exc_sys    (exc_sys),
        .exc_unimpl (exc_unimpl),
        .exc_ovf    (exc_ovf),
        .is_eret    (is_eret),
        .cp0_we     (cp0_we),
        .cp0_addr   (cp0_addr),
        .cp0_wdata  (cp0_wdata),
        .cp0_rdata  (cp0_rdata),
        .selpc      (selpc),
        .epc_out    (epc_out),
        .vec_out    (vec_out),
        .kill       (kill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        inst_valid = 0; exc_sys = 0; exc_unimpl = 0; exc_ovf = 0;
        is_eret = 0; cp0_we = 0; cp0_addr = 5'd0; cp0_wdata = 32'd0;
    endtask

    task automatic m_clear();
        m_status = 12'd0; m_code = 5'd0; m_epc = 32'd0;
        m_hist.delete();
    endtask

    // irq as it was sampled SYNC edges ago
    function automatic logic m_irq_s();
        return (m_hist.size() >= SYNC) ? m_hist[SYNC-1] : 1'b0;
    endfunction

    task automatic m_expect(output logic take, output logic [4:0] code,
                            output logic [1:0] sel, output logic [31:0] rd);
        logic is;
        is   = m_irq_s();
        take = 1'b1;
        code = 5'd0;
        if (inst_valid && exc_ovf && m_status[3])         code = 5'd12;
        else if (inst_valid && exc_unimpl && m_status[2]) code = 5'd10;
        else if (inst_valid && exc_sys && m_status[1])    code = 5'd8;
        else if (inst_valid && is && m_status[0])         code = 5'd0;
        else                                              take = 1'b0;
        if (take)                        sel = 2'b11;
        else if (inst_valid && is_eret)  sel = 2'b10;
        else                             sel = 2'b00;
        case (cp0_addr)
            5'd12:   rd = 32'(m_status);
            5'd13:   rd = 32'(is) * 256 + 32'(m_code) * 4;
            5'd14:   rd = m_epc;
            default: rd = 32'd0;
        endcase
    endtask

    // Advance model with the current inputs, then cross one rising edge.
    task automatic tick();
        logic take; logic [4:0] code; logic [1:0] sel; logic [31:0] rd;
        m_expect(take, code, sel, rd);
        if (take) begin
            m_epc    = pc;
            m_code   = code;
            m_status = 12'((32'(m_status) * 16) % 4096);
        end else begin
            if (inst_valid && is_eret) m_status = m_status / 16;
            if (inst_valid && cp0_we) begin
                case (cp0_addr)
                    5'd12:   m_status = cp0_wdata[11:0];
                    5'd13:   m_code   = cp0_wdata[6:2];
                    5'd14:   m_epc    = cp0_wdata;
                    default: ;
                endcase
            end
        end
        m_hist.push_front(irq);
        if (m_hist.size() > SYNC) void'(m_hist.pop_back());
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle();
        #2 clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        m_clear();
        tick();
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle();
        inst_valid = 1; cp0_we = 1; cp0_addr = a; cp0_wdata = d;
        tick();
        idle();
    endtask

    task automatic test_reset();
        logic [4:0] addrs [3];
        addrs[0] = 5'd12; addrs[1] = 5'd13; addrs[2] = 5'd14;
        mtc0(5'd12, 32'hF);
        mtc0(5'd14, 32'h1234);
        inst_valid = 1; is_eret = 1; pc = 32'h80;
        #2 clrn = 1'b0;
        #1;
        n_cmp++; if (selpc !== 2'b00) begin n_bad++; $display("FAIL reset_selpc: got %0h want 0", selpc); end
        n_cmp++; if (kill !== 1'b0) begin n_bad++; $display("FAIL reset_kill: got %0b want 0", kill); end
        n_cmp++; if (epc_out !== 32'd0) begin n_bad++; $display("FAIL reset_epc: got %0h want 0", epc_out); end
        n_cmp++; if (vec_out !== 32'h8) begin n_bad++; $display("FAIL reset_vec: got %0h want 8", vec_out); end
        for (int i = 0; i < 3; i++) begin
            cp0_addr = addrs[i];
            #1;
            n_cmp++;
            if (cp0_rdata !== 32'd0) begin
                n_bad++; $display("FAIL reset_rdata addr %0d: got %0h want 0", addrs[i], cp0_rdata);
            end
        end
        idle();
        #1 clrn = 1'b1;
        m_clear();
        tick();
        mtc0(5'd12, 32'hF);
        cp0_addr = 5'd12; #1;
        n_cmp++; if (cp0_rdata !== 32'hF) begin n_bad++; $display("FAIL readback_status: got %0h want f", cp0_rdata); end
    endtask

    task automatic test_syscall();
        do_reset();
        mtc0(5'd12, 32'h2);
        inst_valid = 1; pc = 32'h40; exc_sys = 1;
        #2;
        n_cmp++; if (selpc !== 2'b11) begin n_bad++; $display("FAIL sys_selpc: got %0h want 3", selpc); end
        n_cmp++; if (kill !== 1'b1) begin n_bad++; $display("FAIL sys_kill: got %0b want 1", kill); end
        tick(); idle();
        n_cmp++; if (epc_out !== 32'h40) begin n_bad++; $display("FAIL sys_epc: got %0h want 40", epc_out); end
        cp0_addr = 5'd13; #1;
        n_cmp++; if (cp0_rdata !== 32'h20) begin n_bad++; $display("FAIL sys_cause: got %0h want 20", cp0_rdata); end
        cp0_addr = 5'd12; #1;
        n_cmp++; if (cp0_rdata !== 32'h20) begin n_bad++; $display("FAIL sys_status: got %0h want 20", cp0_rdata); end
    endtask

    task automatic test_eret();
        idle();
        inst_valid = 1; is_eret = 1; pc = 32'h44;
        #2;
        n_cmp++; if (selpc !== 2'b10) begin n_bad++; $display("FAIL eret_selpc: got %0h want 2", selpc); end
        n_cmp++; if (kill !== 1'b0) begin n_bad++; $display("FAIL eret_kill: got %0b want 0", kill); end
        n_cmp++; if (epc_out !== 32'h40) begin n_bad++; $display("FAIL eret_epc: got %0h want 40", epc_out); end
        tick(); idle();
        cp0_addr = 5'd12; #1;
        n_cmp++; if (cp0_rdata !== 32'h2) begin n_bad++; $display("FAIL eret_status: got %0h want 2", cp0_rdata); end
    endtask

    task automatic test_priority();
        irq = 0;
        do_reset();
        mtc0(5'd12, 32'hF);
        irq = 1;
        tick(); tick();
        inst_valid = 1; exc_ovf = 1; exc_unimpl = 1; pc = 32'h100;
        #2;
        n_cmp++; if (selpc !== 2'b11) begin n_bad++; $display("FAIL prio_selpc: got %0h want 3", selpc); end
        tick(); idle();
        cp0_addr = 5'd13; #1;
        n_cmp++; if (cp0_rdata !== 32'h130) begin n_bad++; $display("FAIL prio_cause_ovf: got %0h want 130", cp0_rdata); end
        cp0_addr = 5'd12; #1;
        n_cmp++; if (cp0_rdata !== 32'hF0) begin n_bad++; $display("FAIL prio_single_push: got %0h want f0", cp0_rdata); end
        mtc0(5'd12, 32'h7);
        inst_valid = 1; exc_ovf = 1; exc_unimpl = 1; pc = 32'h104;
        #2;
        n_cmp++; if (selpc !== 2'b11) begin n_bad++; $display("FAIL prio2_selpc: got %0h want 3", selpc); end
        tick(); idle();
        cp0_addr = 5'd13; #1;
        n_cmp++; if (cp0_rdata !== 32'h128) begin n_bad++; $display("FAIL prio_cause_unimpl: got %0h want 128", cp0_rdata); end
        cp0_addr = 5'd12; #1;
        n_cmp++; if (cp0_rdata !== 32'h70) begin n_bad++; $display("FAIL prio2_status: got %0h want 70", cp0_rdata); end
        irq = 0;
    endtask

    task automatic test_irq_latency();
        irq = 0;
        do_reset();
        mtc0(5'd12, 32'h1);
        inst_valid = 1; pc = 32'h200; irq = 1;
        #2;
        n_cmp++; if (selpc !== 2'b00) begin n_bad++; $display("FAIL irq_early0: got %0h want 0", selpc); end
        tick();
        pc = 32'h204; #2;
        n_cmp++; if (selpc !== 2'b00) begin n_bad++; $display("FAIL irq_early1: got %0h want 0", selpc); end
        tick();
        pc = 32'h208; #2;
        n_cmp++; if (selpc !== 2'b11) begin n_bad++; $display("FAIL irq_taken_selpc: got %0h want 3", selpc); end
        n_cmp++; if (kill !== 1'b1) begin n_bad++; $display("FAIL irq_taken_kill: got %0b want 1", kill); end
        tick(); idle();
        n_cmp++; if (epc_out !== 32'h208) begin n_bad++; $display("FAIL irq_epc: got %0h want 208", epc_out); end
        cp0_addr = 5'd13; #1;
        n_cmp++; if (cp0_rdata !== 32'h100) begin n_bad++; $display("FAIL irq_cause: got %0h want 100", cp0_rdata); end
        irq = 0;
        do_reset();
        inst_valid = 1; irq = 1;
        for (int i = 0; i < 4; i++) begin
            pc = 32'h300 + 32'(i) * 4;
            #2;
            n_cmp++;
            if (selpc !== 2'b00) begin n_bad++; $display("FAIL irq_masked cycle %0d: got %0h want 0", i, selpc); end
            tick();
        end
        idle();
        cp0_addr = 5'd13; #1;
        n_cmp++; if (cp0_rdata !== 32'h100) begin n_bad++; $display("FAIL irq_masked_cause: got %0h want 100", cp0_rdata); end
        irq = 0;
    endtask

    task automatic test_killed_mtc0_bubble();
        irq = 0;
        do_reset();
        mtc0(5'd12, 32'h1);
        irq = 1;
        tick(); tick();
        inst_valid = 1; cp0_we = 1; cp0_addr = 5'd14; cp0_wdata = 32'hDEAD_BEEF; pc = 32'h300;
        #2;
        n_cmp++; if (selpc !== 2'b11) begin n_bad++; $display("FAIL killmtc0_selpc: got %0h want 3", selpc); end
        tick(); idle();
        n_cmp++; if (epc_out !== 32'h300) begin n_bad++; $display("FAIL killmtc0_epc: got %0h want 300", epc_out); end
        irq = 0;
        tick(); tick();
        mtc0(5'd12, 32'h2);
        inst_valid = 0; exc_sys = 1; pc = 32'h400;
        #2;
        n_cmp++; if (selpc !== 2'b00) begin n_bad++; $display("FAIL bubble_selpc: got %0h want 0", selpc); end
        n_cmp++; if (kill !== 1'b0) begin n_bad++; $display("FAIL bubble_kill: got %0b want 0", kill); end
        tick(); idle();
        cp0_addr = 5'd12; #1;
        n_cmp++; if (cp0_rdata !== 32'h2) begin n_bad++; $display("FAIL bubble_status: got %0h want 2", cp0_rdata); end
        cp0_addr = 5'd13; #1;
        n_cmp++; if (cp0_rdata !== 32'h0) begin n_bad++; $display("FAIL bubble_cause: got %0h want 0", cp0_rdata); end
        n_cmp++; if (epc_out !== 32'h300) begin n_bad++; $display("FAIL bubble_epc: got %0h want 300", epc_out); end
    endtask

    task automatic test_random();
        logic take; logic [4:0] code; logic [1:0] sel; logic [31:0] rd;
        irq = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            inst_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) irq = ~irq;
            exc_sys    = ($urandom_range(0, 5) == 0);
            exc_unimpl = ($urandom_range(0, 5) == 0);
            exc_ovf    = ($urandom_range(0, 5) == 0);
            is_eret    = ($urandom_range(0, 7) == 0);
            cp0_we     = !is_eret && ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       cp0_addr = 5'd12;
                1:       cp0_addr = 5'd13;
                2:       cp0_addr = 5'd14;
                default: cp0_addr = 5'($urandom_range(0, 31));
            endcase
            cp0_wdata = $urandom;
            pc        = $urandom;
            #2;
            m_expect(take, code, sel, rd);
            n_cmp++; if (selpc !== sel) begin n_bad++; $display("FAIL rnd_selpc cycle %0d: got %0h want %0h", c, selpc, sel); end
            n_cmp++; if (kill !== take) begin n_bad++; $display("FAIL rnd_kill cycle %0d: got %0b want %0b", c, kill, take); end
            n_cmp++; if (epc_out !== m_epc) begin n_bad++; $display("FAIL rnd_epc cycle %0d: got %0h want %0h", c, epc_out, m_epc); end
            n_cmp++; if (cp0_rdata !== rd) begin n_bad++; $display("FAIL rnd_rdata cycle %0d addr %0d: got %0h want %0h", c, cp0_addr, cp0_rdata, rd); end
            n_cmp++; if (vec_out !== 32'h8) begin n_bad++; $display("FAIL rnd_vec cycle %0d: got %0h want 8", c, vec_out); end
            tick();
        end
        idle();
        irq = 0;
    endtask

    initial begin
        clrn = 1'b0;
        irq  = 1'b0;
        pc   = 32'd0;
        idle();
        m_clear();
        @(posedge clk); #1;
        do_reset();
        test_reset();
        test_syscall();
        test_eret();
        test_priority();
        test_irq_latency();
        test_killed_mtc0_bubble();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
